// File: rtl/stopwatch_pkg.sv
// Shared types and digit moduli for the stopwatch counter chain.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        CNT_DOWN0 = 2'b00,
        CNT_DOWN1 = 2'b01,
        CNT_UP    = 2'b10,
        CNT_HOLD  = 2'b11
    } cnt_mode_e;

    localparam int unsigned SEC_UNITS_MOD = 10;
    localparam int unsigned SEC_TENS_MOD  = 6;

endpackage

// File: rtl/modn_next.sv
// Combinational next-count for a modulo-N digit: wrap (default) or saturate when
// MODN_CNT_SATURATE_EN is defined. Illegal counts recover to 0.
module modn_next
    import stopwatch_pkg::*;
#(
    parameter int unsigned MODULUS = 6,
    parameter int unsigned WIDTH   = $clog2(MODULUS)
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [1:0]       mode_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    always_comb begin
        next_o = count_i;
        if (count_i > MaxVal) begin
            next_o = '0;
        end else if (en_i) begin
            case (cnt_mode_e'(mode_i))
                CNT_UP: begin
                    if (count_i == MaxVal) begin
`ifdef MODN_CNT_SATURATE_EN
                        next_o = MaxVal;
`else
                        next_o = '0;
`endif
                    end else begin
                        next_o = count_i + One;
                    end
                end
                CNT_DOWN0, CNT_DOWN1: begin
                    if (count_i == '0) begin
`ifdef MODN_CNT_SATURATE_EN
                        next_o = '0;
`else
                        next_o = MaxVal;
`endif
                    end else begin
                        next_o = count_i - One;
                    end
                end
                default: next_o = count_i;
            endcase
        end
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down digit with parallel load, load-range error pulse and cascade outputs.
// Build with MODN_CNT_SATURATE_EN to saturate at the ends instead of wrapping.
module modn_updown_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MODULUS = 6,
    parameter int unsigned WIDTH   = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             carry_o,
    output logic             borrow_o,
    output logic             tc_o,
    output logic             load_err_o
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_d, count_q, next_count;
    logic             load_err_d, load_err_q;
    logic             is_up, is_down, at_max, at_zero;

    modn_next #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .count_i (count_q),
        .mode_i  (mode_i),
        .en_i    (en_i),
        .next_o  (next_count)
    );

    always_comb begin
        count_d    = next_count;
        load_err_d = 1'b0;
        if (load_i) begin
            if (load_val_i > MaxVal) begin
                count_d    = '0;
                load_err_d = 1'b1;
            end else begin
                count_d = load_val_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    // Cascade outputs look at the current state only, so a load never hides a carry.
    always_comb begin
        is_up   = (cnt_mode_e'(mode_i) == CNT_UP);
        is_down = ~mode_i[1];
        at_max  = (count_q == MaxVal);
        at_zero = (count_q == '0);
    end

    assign count_o    = count_q;
    assign load_err_o = load_err_q;
    assign carry_o    = en_i & is_up & at_max;
    assign borrow_o   = en_i & is_down & at_zero;
    assign tc_o       = (is_up & at_max) | (is_down & at_zero);

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter: N=6 digit, N=10 digit and a 10/6 cascade.
module tb_modn_updown_counter;

`ifdef MODN_CNT_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // N=6 digit
    logic       en6 = 1'b0, ld6 = 1'b0;
    logic [1:0] md6 = 2'b11;
    logic [2:0] lv6 = '0;
    logic [2:0] cnt6;
    logic       cy6, bw6, tc6, le6;

    // N=10 digit
    logic       en10 = 1'b0, ld10 = 1'b0;
    logic [1:0] md10 = 2'b11;
    logic [3:0] lv10 = '0;
    logic [3:0] cnt10;
    logic       cy10, bw10, tc10, le10;

    // Cascade: units N=10 feeds tens N=6
    logic       cen = 1'b0;
    logic [1:0] cmd = 2'b10;
    logic       cld = 1'b0;
    logic [3:0] clvu = '0;
    logic [2:0] clvt = '0;
    logic [3:0] cu;
    logic [2:0] ct;
    logic       cyu, bwu, tcu, leu, cyt, bwt, tct, let_t, ten;
    assign ten = cyu | bwu;

    modn_updown_counter #(.MODULUS(6)) u_d6 (
        .clk(clk), .reset(rst), .en_i(en6), .mode_i(md6), .load_i(ld6), .load_val_i(lv6),
        .count_o(cnt6), .carry_o(cy6), .borrow_o(bw6), .tc_o(tc6), .load_err_o(le6)
    );

    modn_updown_counter #(.MODULUS(10)) u_d10 (
        .clk(clk), .reset(rst), .en_i(en10), .mode_i(md10), .load_i(ld10), .load_val_i(lv10),
        .count_o(cnt10), .carry_o(cy10), .borrow_o(bw10), .tc_o(tc10), .load_err_o(le10)
    );

    modn_updown_counter #(.MODULUS(10)) u_units (
        .clk(clk), .reset(rst), .en_i(cen), .mode_i(cmd), .load_i(cld), .load_val_i(clvu),
        .count_o(cu), .carry_o(cyu), .borrow_o(bwu), .tc_o(tcu), .load_err_o(leu)
    );

    modn_updown_counter #(.MODULUS(6)) u_tens (
        .clk(clk), .reset(rst), .en_i(ten), .mode_i(cmd), .load_i(cld), .load_val_i(clvt),
        .count_o(ct), .carry_o(cyt), .borrow_o(bwt), .tc_o(tct), .load_err_o(let_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int c, input int m, input bit up);
        if (up) return (c == m - 1) ? (Sat ? c : 0) : c + 1;
        return (c == 0) ? (Sat ? 0 : m - 1) : c - 1;
    endfunction

    initial begin
        int c, u, t;
        bit cu_carry;

        // Reset, then reset beating a simultaneous load
        tick();
        chk("rst_cnt6", cnt6, 0);
        chk("rst_err6", le6, 0);
        chk("rst_cnt10", cnt10, 0);
        chk("rst_units", cu, 0);
        chk("rst_tens", ct, 0);
        rst = 1'b0;
        ld6 = 1'b1; lv6 = 3'd3;
        tick();
        chk("pre_rst_load3", cnt6, 3);
        rst = 1'b1; lv6 = 3'd4;
        tick();
        chk("rst_over_load_cnt", cnt6, 0);
        chk("rst_over_load_err", le6, 0);
        rst = 1'b0; ld6 = 1'b0;

        // Up count, N=6
        md6 = 2'b10; en6 = 1'b1; c = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("up_carry", cy6, (c == 5) ? 1 : 0);
            chk("up_tc", tc6, (c == 5) ? 1 : 0);
            tick();
            c = nxt(c, 6, 1'b1);
            chk("up_cnt", cnt6, c);
        end

        // Loads: in range with en low, out of range, load beating count
        en6 = 1'b0; ld6 = 1'b1; lv6 = 3'd4;
        tick();
        chk("load4_cnt", cnt6, 4);
        chk("load4_err", le6, 0);
        lv6 = 3'd7;
        tick();
        chk("load7_cnt", cnt6, 0);
        chk("load7_err", le6, 1);
        ld6 = 1'b0;
        tick();
        chk("err_pulse_end", le6, 0);
        chk("hold_en0", cnt6, 0);
        en6 = 1'b1; md6 = 2'b10; ld6 = 1'b1; lv6 = 3'd5;
        #1;
        chk("load5_carry_pre", cy6, 0);
        tick();
        chk("load5_over_count", cnt6, 5);
        lv6 = 3'd2;
        #1;
        chk("load_wrap_carry", cy6, 1);
        tick();
        chk("load_wins_wrap", cnt6, 2);
        chk("load2_err", le6, 0);

        // Saturation region: up from 4, then down from 1
        lv6 = 3'd4;
        tick();
        ld6 = 1'b0; c = 4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("sat_up_carry", cy6, (c == 5) ? 1 : 0);
            tick();
            c = nxt(c, 6, 1'b1);
            chk("sat_up_cnt", cnt6, c);
        end
        ld6 = 1'b1; lv6 = 3'd1; en6 = 1'b0;
        tick();
        ld6 = 1'b0; en6 = 1'b1; md6 = 2'b00; c = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("sat_dn_borrow", bw6, (c == 0) ? 1 : 0);
            chk("sat_dn_carry", cy6, 0);
            tick();
            c = nxt(c, 6, 1'b0);
            chk("sat_dn_cnt", cnt6, c);
        end
        md6 = 2'b11;
        #1;
        chk("hold_tc6", tc6, 0);
        chk("hold_borrow6", bw6, 0);
        tick();
        chk("hold_cnt6", cnt6, c);

        // Down count, N=10, modes 00 then 01, then hold
        ld10 = 1'b1; lv10 = 4'd2;
        tick();
        chk("load2_cnt10", cnt10, 2);
        ld10 = 1'b0; en10 = 1'b1; c = 2;
        for (int i = 0; i < 4; i++) begin
            md10 = (i < 2) ? 2'b00 : 2'b01;
            #1;
            chk("dn_borrow", bw10, (c == 0) ? 1 : 0);
            chk("dn_tc", tc10, (c == 0) ? 1 : 0);
            tick();
            c = nxt(c, 10, 1'b0);
            chk("dn_cnt", cnt10, c);
        end
        md10 = 2'b11;
        #1;
        chk("hold_tc10", tc10, 0);
        chk("hold_borrow10", bw10, 0);
        tick();
        chk("hold_cnt10", cnt10, c);
        ld10 = 1'b1; lv10 = 4'd12;
        tick();
        chk("load12_cnt10", cnt10, 0);
        chk("load12_err10", le10, 1);
        ld10 = 1'b0;
        tick();
        chk("err10_pulse_end", le10, 0);

        // Cascade 00 -> 59 -> 00
        cen = 1'b1; u = 0; t = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            cu_carry = (u == 9);
            chk("cas_tens_carry", cyt, (cu_carry && t == 5) ? 1 : 0);
            tick();
            u = nxt(u, 10, 1'b1);
            if (cu_carry) t = nxt(t, 6, 1'b1);
            chk("cas_units", cu, u);
            chk("cas_tens", ct, t);
        end
        cen = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
